// File: rtl/alu_mul_sequencer.sv
// Shift-add N x N -> 2N unsigned multiplier that drives the shared N-bit ALU
// one add per cycle and asserts busy until the product is ready.
module alu_mul_sequencer #(
   parameter int unsigned N      = 32,
   parameter logic [2:0]  OP_ADD = 3'b010,
   parameter int unsigned CW     = $clog2(N) + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   op_a,
   input  logic [N-1:0]   op_b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] prod,
   output logic [2:0]     alu_c,
   output logic           alu_cin,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   input  logic [N-1:0]   alu_f,
   input  logic           alu_cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   acc, mq, mcand;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] shifted;

   // The (N+1)-bit ALU sum shifted right into the {acc,mq} pair.
   assign shifted = {alu_cout, alu_f, mq[N-1:1]};

   assign alu_c   = OP_ADD;
   assign alu_cin = 1'b0;
   assign alu_a   = acc;
   assign alu_b   = (state == RUN && mq[0]) ? mcand : '0;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         mq    <= '0;
         mcand <= '0;
         cnt   <= '0;
         prod  <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand <= op_a;
                  mq    <= op_b;
                  acc   <= '0;
                  cnt   <= CW'(N);
               end
            end
            RUN: begin
               {acc, mq} <= shifted;
               cnt       <= cnt - CW'(1);
               // Capture on the final iteration so prod is valid alongside done.
               if (cnt == CW'(1)) prod <= shifted;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: 8-bit and 32-bit instances, each
// paired with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

   localparam logic [2:0] OP_ADD = 3'b010;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8-bit instance
   logic        start8, busy8, done8, cin8, cout8;
   logic [7:0]  a8, b8, alua8, alub8, f8;
   logic [15:0] prod8;
   logic [2:0]  c8;

   // 32-bit instance
   logic        start32, busy32, done32, cin32, cout32;
   logic [31:0] a32, b32, alua32, alub32, f32;
   logic [63:0] prod32;
   logic [2:0]  c32;

   always_comb begin
      {cout8, f8} = 9'd0;
      if (c8 == OP_ADD) {cout8, f8} = {1'b0, alua8} + {1'b0, alub8} + {8'd0, cin8};
   end

   always_comb begin
      {cout32, f32} = 33'd0;
      if (c32 == OP_ADD) {cout32, f32} = {1'b0, alua32} + {1'b0, alub32} + {32'd0, cin32};
   end

   alu_mul_sequencer #(.N(8), .OP_ADD(OP_ADD)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
      .busy(busy8), .done(done8), .prod(prod8),
      .alu_c(c8), .alu_cin(cin8), .alu_a(alua8), .alu_b(alub8),
      .alu_f(f8), .alu_cout(cout8)
   );

   alu_mul_sequencer #(.N(32), .OP_ADD(OP_ADD)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .op_a(a32), .op_b(b32),
      .busy(busy32), .done(done32), .prod(prod32),
      .alu_c(c32), .alu_cin(cin32), .alu_a(alua32), .alu_b(alub32),
      .alu_f(f32), .alu_cout(cout32)
   );

   // View of whichever instance is under test.
   bit          wide_sel;
   logic        s_busy, s_done, s_cin;
   logic [2:0]  s_c;
   logic [63:0] s_prod, s_alub;
   always_comb begin
      s_busy = wide_sel ? busy32 : busy8;
      s_done = wide_sel ? done32 : done8;
      s_cin  = wide_sel ? cin32  : cin8;
      s_c    = wide_sel ? c32    : c8;
      s_prod = wide_sel ? prod32 : {48'd0, prod8};
      s_alub = wide_sel ? {32'd0, alub32} : {56'd0, alub8};
   end

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Samples from the current negedge until done, bounded by a cycle budget.
   task automatic wait_done(input int n, output bit got, output logic [63:0] p,
                            output int bc, output int bnz);
      got = 0; p = '0; bc = 0; bnz = 0;
      for (int i = 0; i < n + 10; i++) begin
         if (s_busy) bc++;
         if (s_busy && s_alub != 0) bnz++;
         if (s_done) begin
            got = 1;
            p   = s_prod;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_mul(input bit wide, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string tag);
      bit got; logic [63:0] p; int bc, bnz; int n;
      n = wide ? 32 : 8;
      wide_sel = wide;
      @(negedge clk);
      if (wide) begin a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1; end
      else      begin a8  = a[7:0];  b8  = b[7:0];  start8  = 1'b1; end
      @(negedge clk);
      start8 = 1'b0; start32 = 1'b0;
      chk({tag, " alu_ctl"}, {61'd0, s_c}, {61'd0, OP_ADD});
      chk({tag, " alu_cin"}, {63'd0, s_cin}, 64'd0);
      wait_done(n, got, p, bc, bnz);
      chk({tag, " done_seen"}, {63'd0, got}, 64'd1);
      chk({tag, " busy_cycles"}, 64'(bc), 64'(n));
      chk({tag, " busy_at_done"}, {63'd0, s_busy}, 64'd0);
      chk({tag, " prod"}, p, exp);
      if (b == 0) chk({tag, " alu_b_zero"}, 64'(bnz), 64'd0);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, {63'd0, s_done}, 64'd0);
      chk({tag, " prod_held"}, s_prod, exp);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;
   vec_t tbl[7];

   initial begin
      bit got; logic [63:0] p; int bc, bnz;

      tbl[0] = '{8'd13,  8'd11,  16'd143};
      tbl[1] = '{8'hFF,  8'hFF,  16'hFE01};
      tbl[2] = '{8'h00,  8'hFF,  16'h0000};
      tbl[3] = '{8'hFF,  8'h00,  16'h0000};
      tbl[4] = '{8'h80,  8'h02,  16'h0100};
      tbl[5] = '{8'hFF,  8'h01,  16'h00FF};
      tbl[6] = '{8'd1,   8'd1,   16'd1};

      wide_sel = 0;
      rst_n = 1'b0; start8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
      start32 = 1'b0; a32 = '0; b32 = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", {63'd0, busy8}, 64'd0);
      chk("rst done", {63'd0, done8}, 64'd0);
      chk("rst prod", {48'd0, prod8}, 64'd0);
      chk("rst alu_b", {56'd0, alub8}, 64'd0);
      chk("rst busy32", {63'd0, busy32}, 64'd0);
      start8 = 1'b0;
      rst_n  = 1'b1;
      @(negedge clk);
      chk("post_rst idle", {63'd0, busy8}, 64'd0);

      for (int i = 0; i < 7; i++)
         run_mul(0, {56'd0, tbl[i].a}, {56'd0, tbl[i].b}, {48'd0, tbl[i].p}, $sformatf("v%0d", i));

      run_mul(1, 64'hFFFFFFFF, 64'h2, 64'h00000001FFFFFFFE, "w32");

      // Held start with operands changed mid-RUN
      wide_sel = 0;
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd3;
      wait_done(8, got, p, bc, bnz);
      chk("hold done_seen", {63'd0, got}, 64'd1);
      chk("hold busy_cycles", 64'(bc), 64'd8);
      chk("hold prod", p, 64'd45);
      @(negedge clk);
      chk("hold idle_busy", {63'd0, busy8}, 64'd0);
      chk("hold idle_done", {63'd0, done8}, 64'd0);
      @(negedge clk);
      chk("hold reaccept", {63'd0, busy8}, 64'd1);
      start8 = 1'b0;
      wait_done(8, got, p, bc, bnz);
      chk("hold2 done_seen", {63'd0, got}, 64'd1);
      chk("hold2 busy_cycles", 64'(bc), 64'd8);
      chk("hold2 prod", p, 64'd9);

      // Reset asserted during RUN cycle 4
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid busy_before", {63'd0, busy8}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid busy_async", {63'd0, busy8}, 64'd0);
      chk("mid done", {63'd0, done8}, 64'd0);
      chk("mid prod", {48'd0, prod8}, 64'd0);
      chk("mid alu_b", {56'd0, alub8}, 64'd0);
      start8 = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid held_busy", {63'd0, busy8}, 64'd0);
      chk("mid held_done", {63'd0, done8}, 64'd0);
      start8 = 1'b0;
      rst_n  = 1'b1;
      run_mul(0, 64'd6, 64'd7, 64'd42, "after_rst");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
